// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx
// Purpose  : 8N1 UART receiver, mid-bit sampling behind a 2-flop synchronizer.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       busy
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_START     = 3'd1;
    localparam logic [2:0] S_DATA      = 3'd2;
    localparam logic [2:0] S_STOP      = 3'd3;
    localparam logic [2:0] S_WAIT_HIGH = 3'd4;

    logic [2:0]       state_q, state_d;
    logic             sync1_q, rx_s_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       rx_data_q, rx_data_d;
    logic             rx_valid_q, rx_valid_d;
    logic             frame_err_q, frame_err_d;

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1_q     <= 1'b1;
            rx_s_q      <= 1'b1;
            cnt_q       <= '0;
            idx_q       <= 3'd0;
            shift_q     <= 8'h00;
            rx_data_q   <= 8'h00;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            sync1_q     <= rx;
            rx_s_q      <= sync1_q;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            shift_q     <= shift_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:      if (!rx_s_q) state_d = S_START;
            S_START:     if (cnt_q == HALF_LAST) state_d = rx_s_q ? S_IDLE : S_DATA;
            S_DATA:      if (cnt_q == BIT_LAST && idx_q == 3'd7) state_d = S_STOP;
            S_STOP:      if (cnt_q == BIT_LAST) state_d = rx_s_q ? S_IDLE : S_WAIT_HIGH;
            S_WAIT_HIGH: if (rx_s_q) state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase
    end

    // Counters, shift register and registered pulses
    always_comb begin
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        shift_d     = shift_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        frame_err_d = 1'b0;
        case (state_q)
            S_START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d = '0;
                    idx_d = 3'd0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d          = '0;
                    shift_d[idx_q] = rx_s_q;
                    idx_d          = idx_q + 3'd1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d = '0;
                    if (rx_s_q) begin
                        rx_data_d  = shift_q;
                        rx_valid_d = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                cnt_d = '0;
                idx_d = 3'd0;
            end
        endcase
    end

    // Outputs
    always_comb begin
        busy      = (state_q != S_IDLE);
        rx_data   = rx_data_q;
        rx_valid  = rx_valid_q;
        frame_err = frame_err_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx
// Purpose  : Directed self-checking bench for uart_rx at CLKS_PER_BIT = 8.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx;

    localparam int CPB = 8;

    logic       clk;
    logic       rst;
    logic       rx;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       busy;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int valid_cnt = 0;
    int fe_cnt    = 0;
    int both_cnt  = 0;
    int last_valid_cyc = 0;
    int start_cyc = 0;
    logic [7:0] got_q[$];

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .frame_err (frame_err),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Pulse monitor, sampled on the falling edge
    always @(negedge clk) begin
        if (rx_valid) begin
            valid_cnt      = valid_cnt + 1;
            last_valid_cyc = cyc;
            got_q.push_back(rx_data);
        end
        if (frame_err) fe_cnt = fe_cnt + 1;
        if (rx_valid && frame_err) both_cnt = both_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            failures = failures + 1;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_bit(input logic b);
        rx = b;
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] d, input logic stop);
        @(posedge clk);
        #1;
        start_cyc = cyc;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        drive_bit(stop);
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    logic [7:0] popped;
    int v0;
    int f0;
    int lat;

    initial begin
        rst = 1'b0;
        rx  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_rx_data",   {24'd0, rx_data},   32'h00);
        check("reset_rx_valid",  {31'd0, rx_valid},  32'h0);
        check("reset_frame_err", {31'd0, frame_err}, 32'h0);
        check("reset_busy",      {31'd0, busy},      32'h0);
        rst = 1'b1;
        idle(5);

        // Single frame
        v0 = valid_cnt; f0 = fe_cnt;
        send_byte(8'h35, 1'b1);
        idle(4);
        check("single_valid_cnt", valid_cnt - v0, 1);
        check("single_data",      {24'd0, rx_data}, 32'h35);
        check("single_fe_cnt",    fe_cnt - f0, 0);
        got_q.delete();

        // Back-to-back frames, no idle gap
        v0 = valid_cnt;
        send_byte(8'h30, 1'b1);
        send_byte(8'h39, 1'b1);
        send_byte(8'h41, 1'b1);
        idle(4);
        check("b2b_valid_cnt", valid_cnt - v0, 3);
        popped = (got_q.size() > 0) ? got_q.pop_front() : 8'hxx;
        check("b2b_data0", {24'd0, popped}, 32'h30);
        popped = (got_q.size() > 0) ? got_q.pop_front() : 8'hxx;
        check("b2b_data1", {24'd0, popped}, 32'h39);
        popped = (got_q.size() > 0) ? got_q.pop_front() : 8'hxx;
        check("b2b_data2", {24'd0, popped}, 32'h41);

        // Glitch rejection
        v0 = valid_cnt; f0 = fe_cnt;
        @(posedge clk); #1;
        rx = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rx = 1'b1;
        repeat (CPB / 2 + 3) @(posedge clk);
        #1;
        check("glitch_busy",      {31'd0, busy}, 32'h0);
        idle(20);
        check("glitch_valid_cnt", valid_cnt - v0, 0);
        check("glitch_fe_cnt",    fe_cnt - f0, 0);

        // Framing error then recovery
        v0 = valid_cnt; f0 = fe_cnt;
        send_byte(8'hA5, 1'b0);
        rx = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        idle(20);
        check("ferr_fe_cnt",    fe_cnt - f0, 1);
        check("ferr_valid_cnt", valid_cnt - v0, 0);
        check("ferr_data_held", {24'd0, rx_data}, 32'h41);
        check("ferr_busy_idle", {31'd0, busy}, 32'h0);
        send_byte(8'h0F, 1'b1);
        idle(4);
        check("ferr_recover_cnt",  valid_cnt - v0, 1);
        check("ferr_recover_data", {24'd0, rx_data}, 32'h0F);

        // Reset in the middle of data bits
        v0 = valid_cnt; f0 = fe_cnt;
        @(posedge clk); #1;
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b1);
        drive_bit(1'b1);
        rst = 1'b0;
        rx  = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        idle(CPB * 10);
        check("rst_valid_cnt", valid_cnt - v0, 0);
        check("rst_fe_cnt",    fe_cnt - f0, 0);
        check("rst_data",      {24'd0, rx_data}, 32'h00);
        send_byte(8'h12, 1'b1);
        idle(4);
        check("rst_next_data", {24'd0, rx_data}, 32'h12);

        // Latency: 2 + CPB/2 + 9*CPB = 78 cycles, +/-1
        v0 = valid_cnt;
        send_byte(8'h55, 1'b1);
        idle(4);
        check("lat_valid_cnt", valid_cnt - v0, 1);
        check("lat_data",      {24'd0, rx_data}, 32'h55);
        lat = last_valid_cyc - start_cyc;
        check("lat_window", {31'd0, (lat >= 77) && (lat <= 79)}, 32'h1);

        check("valid_and_ferr_overlap", both_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
